branch_resolver: RTL and testbench
==================================

# branch_resolver

Tracks every branch the fetch stage has predicted, in program order, and checks each one against the actual outcome computed in the ALU stage. For each resolved branch it drives the gshare predictor's update/reconcile inputs. On a misprediction it raises a one-cycle pipeline flush with the correct redirect PC and discards all younger in-flight branches. It sits between fetch, the ALU stage and `branch_predictor`, and keeps saturating branch and misprediction counters for performance monitoring.

## Interface
- ADDRESS_WIDTH, 22, width of word-addressed PCs and targets
- GHR_SIZE, 8, number of PC bits forwarded to the predictor's update port
- DEPTH, 4, in-flight branch queue entries; must be a power of two, minimum 2

- i_Clk  in  1  system clock, rising edge
- i_Reset_n  in  1  asynchronous active-low reset
- i_Stall  in  1  pipeline stall; freezes the queue and the counters
- i_fetch_valid  in  1  a predicted branch enters the queue this cycle
- i_fetch_pc  in  ADDRESS_WIDTH  PC of the fetched branch
- i_fetch_prediction  in  1  predicted direction: 1 = taken
- i_fetch_target  in  ADDRESS_WIDTH  predicted taken target
- o_queue_full  out  1  the queue holds DEPTH entries (combinational from the occupancy count)
- i_resolve_valid  in  1  the ALU has resolved the oldest in-flight branch
- i_resolve_taken  in  1  actual direction of that branch
- i_resolve_target  in  ADDRESS_WIDTH  actual taken target of that branch
- o_isbranch_check  out  1  predictor update strobe
- o_ALU_isbranch  out  1  same value as o_isbranch_check
- o_ALU_outcome  out  1  actual direction
- o_ALU_prediction  out  1  direction that was predicted
- o_ALU_pc  out  GHR_SIZE  low GHR_SIZE bits of the branch PC
- o_flush  out  1  one-cycle misprediction flush pulse
- o_redirect_pc  out  ADDRESS_WIDTH  correct next PC; valid only while o_flush is high
- o_branch_count  out  32  number of resolved branches, saturating
- o_mispredict_count  out  32  number of mispredictions, saturating
- o_error  out  1  sticky error flag: overflow or underflow

## Operation
- **Queue:** circular FIFO with head pointer, tail pointer and an occupancy count of width log2(DEPTH)+1. Each entry holds {pc, prediction, target}. Pointers wrap modulo DEPTH.
- **Push:** accepted when i_fetch_valid is high, i_Stall is low, and either the queue is not full or a pop happens in the same cycle.
  - A push to a full queue with no pop is dropped and sets o_error.
- **Pop:** accepted when i_resolve_valid is high, i_Stall is low and the queue is not empty; it consumes the head entry.
  - A resolve against an empty queue is ignored (no update, no flush) and sets o_error.
- **Mispredict detection on the popped entry:**
  - direction mismatch (i_resolve_taken != prediction), or
  - both taken and i_resolve_target != the stored target.
- **Redirect PC:** i_resolve_target if the branch was actually taken; otherwise the stored pc+1, modulo 2^ADDRESS_WIDTH.
- **On a mispredict:**
  - reset head, tail and count to an empty queue;
  - drop any push in the same cycle, since it is wrong-path;
  - increment o_mispredict_count.
- **On every accepted pop:** increment o_branch_count. Both counters saturate at 32'hFFFFFFFF.
- **Stall:** no push or pop. The registered strobes (o_isbranch_check, o_ALU_isbranch, o_flush) are low on the following cycle; the data outputs hold their values.
- o_error clears only on reset.

## Timing
- **Reset:** every output is 0; the queue is empty, o_queue_full = 0, o_error = 0.
- **Resolve latency:** a pop accepted at edge N drives the predictor outputs and o_flush/o_redirect_pc, registered, during cycle N+1.
  - Each strobe is high for exactly one cycle per accepted pop.
  - Data outputs hold their values between strobes.
- **Counters:** o_branch_count and o_mispredict_count update at edge N and are visible in cycle N+1, together with the strobes.
- **Queue state:** a push at edge N is visible in o_queue_full from cycle N+1.
- **Simultaneous push and pop with no mispredict:** the count is unchanged; this is legal when the queue is full.
- **Back-to-back resolves:** one per cycle is supported, including a flush followed by a resolve against the now-empty queue, which is an underflow.
- **Reset asserted mid-operation:** the queue empties and outputs clear immediately; in-flight strobes are lost.

## Test plan
- Reset, then push 4 branches with no resolve → o_queue_full = 1; a 5th push → dropped, o_error = 1.
- Push pc=0x100, pred=1, tgt=0x200; resolve taken, tgt=0x200 → next cycle o_isbranch_check = 1, o_ALU_pc = 8'h00, o_ALU_outcome = 1, o_flush = 0, o_branch_count = 1.
- Push pc=0x3F5, pred=1; push two more; resolve not-taken → o_flush = 1, o_redirect_pc = 0x3F6, o_mispredict_count = 1, queue empty (next resolve sets o_error).
- Push pred=1, tgt=0x40; resolve taken, tgt=0x44 → o_flush = 1, o_redirect_pc = 0x44 (target mispredict).
- Full queue with simultaneous push and correct resolve for 10 cycles → the count stays 4, no error, o_branch_count = 10; the same scenario with i_Stall = 1 → nothing changes and all strobes are 0.
- Assert i_Reset_n = 0 mid-stream with 3 entries queued → all outputs 0 asynchronously; after release, a resolve sets o_error.

Source files
------------

// File: rtl/branch_resolver.sv
// In-order in-flight branch queue: checks each predicted branch against its ALU
// outcome, drives predictor update strobes and raises a flush on mispredict.
module branch_resolver #(
  parameter int ADDRESS_WIDTH = 22,
  parameter int GHR_SIZE      = 8,
  parameter int DEPTH         = 4
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Stall,
  input  logic                     i_fetch_valid,
  input  logic [ADDRESS_WIDTH-1:0] i_fetch_pc,
  input  logic                     i_fetch_prediction,
  input  logic [ADDRESS_WIDTH-1:0] i_fetch_target,
  output logic                     o_queue_full,
  input  logic                     i_resolve_valid,
  input  logic                     i_resolve_taken,
  input  logic [ADDRESS_WIDTH-1:0] i_resolve_target,
  output logic                     o_isbranch_check,
  output logic                     o_ALU_isbranch,
  output logic                     o_ALU_outcome,
  output logic                     o_ALU_prediction,
  output logic [GHR_SIZE-1:0]      o_ALU_pc,
  output logic                     o_flush,
  output logic [ADDRESS_WIDTH-1:0] o_redirect_pc,
  output logic [31:0]              o_branch_count,
  output logic [31:0]              o_mispredict_count,
  output logic                     o_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDRESS_WIDTH-1:0] r_pc_mem   [DEPTH];
  logic                     r_pred_mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] r_tgt_mem  [DEPTH];

  logic [PW-1:0] r_head, r_tail;
  logic [CW-1:0] r_count;

  logic                     r_strobe, r_flush, r_outcome, r_prediction, r_error;
  logic [GHR_SIZE-1:0]      r_alu_pc;
  logic [ADDRESS_WIDTH-1:0] r_redirect;
  logic [31:0]              r_branch_count, r_mispredict_count;

  logic                     w_full, w_empty, w_resolve_req, w_pop, w_push_req, w_push;
  logic                     w_mispredict, w_overflow, w_underflow;
  logic [ADDRESS_WIDTH-1:0] w_head_pc, w_head_tgt, w_redirect;
  logic                     w_head_pred;

  assign w_full        = (r_count == CW'(DEPTH));
  assign w_empty       = (r_count == '0);
  assign w_head_pc     = r_pc_mem[r_head];
  assign w_head_pred   = r_pred_mem[r_head];
  assign w_head_tgt    = r_tgt_mem[r_head];

  assign w_resolve_req = i_resolve_valid & ~i_Stall;
  assign w_pop         = w_resolve_req & ~w_empty;
  assign w_mispredict  = w_pop & ((i_resolve_taken != w_head_pred) |
                         (i_resolve_taken & w_head_pred & (i_resolve_target != w_head_tgt)));
  assign w_push_req    = i_fetch_valid & ~i_Stall;
  // a push alongside a mispredicting pop is wrong-path and silently dropped
  assign w_push        = w_push_req & (~w_full | w_pop) & ~w_mispredict;
  assign w_overflow    = w_push_req & w_full & ~w_pop;
  assign w_underflow   = w_resolve_req & w_empty;
  assign w_redirect    = i_resolve_taken ? i_resolve_target
                                         : w_head_pc + ADDRESS_WIDTH'(1);

  always_ff @(posedge i_Clk) begin
    if (w_push) begin
      r_pc_mem[r_tail]   <= i_fetch_pc;
      r_pred_mem[r_tail] <= i_fetch_prediction;
      r_tgt_mem[r_tail]  <= i_fetch_target;
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_mispredict) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_strobe           <= 1'b0;
      r_flush            <= 1'b0;
      r_outcome          <= 1'b0;
      r_prediction       <= 1'b0;
      r_alu_pc           <= '0;
      r_redirect         <= '0;
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
      r_error            <= 1'b0;
    end else begin
      r_strobe <= w_pop;
      r_flush  <= w_mispredict;
      if (w_pop) begin
        r_outcome    <= i_resolve_taken;
        r_prediction <= w_head_pred;
        r_alu_pc     <= w_head_pc[GHR_SIZE-1:0];
        r_redirect   <= w_redirect;
        if (r_branch_count != '1) r_branch_count <= r_branch_count + 32'd1;
      end
      if (w_mispredict && r_mispredict_count != '1)
        r_mispredict_count <= r_mispredict_count + 32'd1;
      if (w_overflow || w_underflow) r_error <= 1'b1;
    end
  end

  assign o_queue_full       = w_full;
  assign o_isbranch_check   = r_strobe;
  assign o_ALU_isbranch     = r_strobe;
  assign o_ALU_outcome      = r_outcome;
  assign o_ALU_prediction   = r_prediction;
  assign o_ALU_pc           = r_alu_pc;
  assign o_flush            = r_flush;
  assign o_redirect_pc      = r_redirect;
  assign o_branch_count     = r_branch_count;
  assign o_mispredict_count = r_mispredict_count;
  assign o_error            = r_error;

endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model predicts
// each resolve response; a negedge monitor compares whenever the strobe appears.
module tb_branch_resolver;
  localparam int AW = 22;
  localparam int GW = 8;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall = 1'b0, fv = 1'b0, fpred = 1'b0, rv = 1'b0, rtaken = 1'b0;
  logic [AW-1:0] fpc = '0, ftgt = '0, rtgt = '0;
  logic          o_queue_full, o_isbranch_check, o_ALU_isbranch, o_ALU_outcome;
  logic          o_ALU_prediction, o_flush, o_error;
  logic [GW-1:0] o_ALU_pc;
  logic [AW-1:0] o_redirect_pc;
  logic [31:0]   o_branch_count, o_mispredict_count;

  always #5 clk = ~clk;

  branch_resolver #(.ADDRESS_WIDTH(AW), .GHR_SIZE(GW), .DEPTH(D)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Stall(stall),
    .i_fetch_valid(fv), .i_fetch_pc(fpc), .i_fetch_prediction(fpred),
    .i_fetch_target(ftgt), .o_queue_full(o_queue_full),
    .i_resolve_valid(rv), .i_resolve_taken(rtaken), .i_resolve_target(rtgt),
    .o_isbranch_check(o_isbranch_check), .o_ALU_isbranch(o_ALU_isbranch),
    .o_ALU_outcome(o_ALU_outcome), .o_ALU_prediction(o_ALU_prediction),
    .o_ALU_pc(o_ALU_pc), .o_flush(o_flush), .o_redirect_pc(o_redirect_pc),
    .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count),
    .o_error(o_error)
  );

  typedef struct { logic [AW-1:0] pc; logic pred; logic [AW-1:0] tgt; } ent_t;
  typedef struct { logic outcome; logic pred; logic [GW-1:0] pc; logic flush; logic [AW-1:0] redirect; } exp_t;

  ent_t        mq[$];
  exp_t        sbq[$];
  exp_t        last;
  bit          m_err;
  int unsigned m_bc, m_mc;
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sbq.delete();
    m_err = 0; m_bc = 0; m_mc = 0;
    last = '{1'b0, 1'b0, '0, 1'b0, '0};
  endtask

  task automatic model_step(input bit f, input logic [AW-1:0] p, input bit pr,
                            input logic [AW-1:0] t, input bit r, input bit tk,
                            input logic [AW-1:0] rt, input bit st);
    int   n0;
    bit   pop, mis;
    ent_t h;
    exp_t e;
    if (st) return;
    n0  = mq.size();
    pop = r && (n0 > 0);
    mis = 0;
    if (r && n0 == 0) m_err = 1;
    if (pop) begin
      h   = mq.pop_front();
      mis = (tk != h.pred) || (tk && h.pred && rt != h.tgt);
      e.outcome  = tk;
      e.pred     = h.pred;
      e.pc       = h.pc[GW-1:0];
      e.flush    = mis;
      e.redirect = tk ? rt : AW'(h.pc + 1);
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
      if (mis && m_mc != 32'hFFFF_FFFF) m_mc++;
      sbq.push_back(e);
    end
    if (mis) mq.delete();
    else if (f) begin
      if (n0 == D && !pop) m_err = 1;
      else mq.push_back('{p, pr, t});
    end
  endtask

  task automatic cyc(input bit f, input logic [AW-1:0] p, input bit pr, input logic [AW-1:0] t,
                     input bit r, input bit tk, input logic [AW-1:0] rt, input bit st);
    @(negedge clk);
    #1;
    fv = f; fpc = p; fpred = pr; ftgt = t;
    rv = r; rtaken = tk; rtgt = rt; stall = st;
    @(posedge clk);
    model_step(f, p, pr, t, r, tk, rt, st);
  endtask

  task automatic check_zero(input string name);
    check({name, "_bits"}, {o_queue_full, o_isbranch_check, o_ALU_isbranch, o_ALU_outcome,
                            o_ALU_prediction, o_flush, o_error, o_ALU_pc, o_redirect_pc}, '0);
    check({name, "_counts"}, {o_branch_count, o_mispredict_count}, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    fv = 0; rv = 0; stall = 0;
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    model_clear();
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n) begin
      check_zero("reset_hold");
    end else begin
      check("queue_full", o_queue_full, 64'(mq.size() == D));
      check("error", o_error, 64'(m_err));
      check("branch_count", o_branch_count, 64'(m_bc));
      check("mispredict_count", o_mispredict_count, 64'(m_mc));
      if (o_isbranch_check) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_strobe: got 1 expected 0 at %0t", $time);
        end else begin
          e = sbq.pop_front();
          check("alu_isbranch", o_ALU_isbranch, 1);
          check("alu_outcome", o_ALU_outcome, 64'(e.outcome));
          check("alu_prediction", o_ALU_prediction, 64'(e.pred));
          check("alu_pc", o_ALU_pc, 64'(e.pc));
          check("flush", o_flush, 64'(e.flush));
          if (e.flush) check("redirect_pc", o_redirect_pc, 64'(e.redirect));
          last = e;
        end
      end else begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          n_checks++; n_fail++;
          $display("FAIL missing_strobe: got 0 expected 1 at %0t", $time);
        end
        check("idle_isbranch", o_ALU_isbranch, 0);
        check("idle_flush", o_flush, 0);
        check("hold_data", {o_ALU_outcome, o_ALU_prediction, o_ALU_pc},
              {last.outcome, last.pred, last.pc});
      end
    end
  end

  initial begin
    logic [AW-1:0] tsel [2];
    tsel[0] = 22'h40; tsel[1] = 22'h44;
    model_clear();
    #1 check_zero("power_on_reset");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;

    // fill, then overflow
    for (int i = 0; i < D; i++) cyc(1, AW'(i + 1), 1, 22'h10, 0, 0, '0, 0);
    #1 check("full_after_4", o_queue_full, 1);
    cyc(1, 22'h99, 1, 22'h10, 0, 0, '0, 0);
    #1 check("overflow_error", o_error, 1);
    do_reset();

    // correct taken prediction
    cyc(1, 22'h100, 1, 22'h200, 0, 0, '0, 0);
    cyc(0, '0, 0, '0, 1, 1, 22'h200, 0);
    #1 check("ok_strobe", o_isbranch_check, 1);
    check("ok_pc", o_ALU_pc, 8'h00);
    check("ok_outcome", o_ALU_outcome, 1);
    check("ok_flush", o_flush, 0);
    check("ok_count", o_branch_count, 1);

    // direction mispredict, then resolve against the flushed queue
    cyc(1, 22'h3F5, 1, 22'h10, 0, 0, '0, 0);
    cyc(1, 22'h3F6, 0, 22'h20, 0, 0, '0, 0);
    cyc(1, 22'h3F7, 1, 22'h30, 0, 0, '0, 0);
    cyc(0, '0, 0, '0, 1, 0, 22'h55, 0);
    #1 check("dir_flush", o_flush, 1);
    check("dir_redirect", o_redirect_pc, 22'h3F6);
    check("dir_mcount", o_mispredict_count, 1);
    cyc(0, '0, 0, '0, 1, 1, 22'h10, 0);
    #1 check("underflow_error", o_error, 1);
    check("underflow_no_strobe", o_isbranch_check, 0);
    do_reset();

    // target mispredict
    cyc(1, 22'h500, 1, 22'h40, 0, 0, '0, 0);
    cyc(0, '0, 0, '0, 1, 1, 22'h44, 0);
    #1 check("tgt_flush", o_flush, 1);
    check("tgt_redirect", o_redirect_pc, 22'h44);
    do_reset();

    // full queue streaming, then stalled
    for (int i = 0; i < D; i++) cyc(1, AW'(22'h600 + i), 1, 22'h80, 0, 0, '0, 0);
    for (int i = 0; i < 10; i++) cyc(1, AW'(22'h700 + i), 1, 22'h80, 1, 1, 22'h80, 0);
    #1 check("stream_count", o_branch_count, 10);
    check("stream_full", o_queue_full, 1);
    check("stream_error", o_error, 0);
    for (int i = 0; i < 10; i++) cyc(1, AW'(22'h800 + i), 1, 22'h80, 1, 1, 22'h80, 1);
    #1 check("stall_count", o_branch_count, 10);
    check("stall_strobe", o_isbranch_check, 0);

    // reset with 3 entries in flight
    cyc(0, '0, 0, '0, 1, 1, 22'h80, 0);
    do_reset();
    cyc(0, '0, 0, '0, 1, 1, 22'h80, 0);
    #1 check("post_reset_underflow", o_error, 1);
    do_reset();

    for (int i = 0; i < 600; i++) begin
      logic [AW-1:0] p;
      p = ($urandom_range(0, 15) == 0) ? 22'h3FFFFF : AW'($urandom);
      cyc($urandom_range(0, 99) < 60, p, $urandom_range(0, 3) != 0, tsel[$urandom_range(0, 1)],
          $urandom_range(0, 99) < 50, $urandom_range(0, 3) != 0, tsel[$urandom_range(0, 1)],
          $urandom_range(0, 99) < 10);
    end
    repeat (3) cyc(0, '0, 0, '0, 0, 0, '0, 0);
    #1 check("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
